// File: rtl/cnn_conv_3x3_dilation_multi_channel.sv
// Multi-channel 3x3 dilated convolution, signed Q16.16, serial weight/pixel load and serial output.
// Define CONV_RELU_EN to clamp negative outputs to zero.
module cnn_conv_3x3_dilation_multi_channel #(
  parameter int unsigned IMAGE_WIDTH     = 32,
  parameter int unsigned IMAGE_HEIGHT    = 32,
  parameter int unsigned CHANNEL_NUM_IN  = 4,
  parameter int unsigned CHANNEL_NUM_OUT = 1,
  parameter int unsigned KERNEL          = 3,
  parameter int unsigned RATE            = 1,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stride2,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  valid_weight_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out
);
  localparam int unsigned KK         = KERNEL * KERNEL;
  localparam int unsigned WEIGHT_NUM = KK * CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
  localparam int unsigned PIX_NUM    = CHANNEL_NUM_IN * IMAGE_HEIGHT * IMAGE_WIDTH;
  localparam int unsigned WAW        = $clog2(WEIGHT_NUM);
  localparam int unsigned PFW        = $clog2(PIX_NUM);
  localparam int unsigned PAW        = $clog2(PIX_NUM + 1);
  localparam int unsigned XW         = $clog2(IMAGE_WIDTH + 2);
  localparam int unsigned YW         = $clog2(IMAGE_HEIGHT + 2);
  localparam int unsigned ICW        = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int unsigned OCW        = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

  localparam logic [0:0] S_LOAD    = 1'b0;
  localparam logic [0:0] S_COMPUTE = 1'b1;

  logic [0:0]            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_wmem [WEIGHT_NUM];
  logic [DATA_WIDTH-1:0] r_fmem [PIX_NUM];
  logic [WAW-1:0]        r_w_cnt, w_w_cnt_nxt;
  logic                  r_w_full, w_w_full_nxt;
  logic [PAW-1:0]        r_pix_cnt, w_pix_cnt_nxt;
  logic                  r_stride;
  logic [OCW-1:0]        r_oc;
  logic [YW-1:0]         r_y, w_y_inc;
  logic [XW-1:0]         r_x, w_x_inc;
  logic [ICW-1:0]        r_ic;
  logic                  w_w_acc, w_p_acc, w_w_wrap, w_start, w_done;
  logic                  w_ic_last, w_x_last, w_y_last, w_oc_last;
  logic [DATA_WIDTH-1:0] w_sum, w_acc_nxt, w_out;
  logic                  r_s1_vld, r_s1_first, r_s1_last;
  logic [DATA_WIDTH-1:0] r_s1_sum, r_acc;

  // Load bookkeeping: compute may start only with a complete, not partially rewritten, weight set.
  assign w_w_acc       = (r_state == S_LOAD) && valid_weight_in;
  assign w_p_acc       = (r_state == S_LOAD) && valid_in && (r_pix_cnt != PAW'(PIX_NUM));
  assign w_w_wrap      = (r_w_cnt == WAW'(WEIGHT_NUM - 1));
  assign w_w_cnt_nxt   = w_w_acc ? (w_w_wrap ? '0 : r_w_cnt + WAW'(1)) : r_w_cnt;
  assign w_w_full_nxt  = r_w_full || (w_w_acc && w_w_wrap);
  assign w_pix_cnt_nxt = r_pix_cnt + PAW'(w_p_acc);
  assign w_start       = (r_state == S_LOAD) && (w_pix_cnt_nxt == PAW'(PIX_NUM)) &&
                         w_w_full_nxt && (w_w_cnt_nxt == '0);

  assign w_x_inc   = r_x + (r_stride ? XW'(2) : XW'(1));
  assign w_y_inc   = r_y + (r_stride ? YW'(2) : YW'(1));
  assign w_ic_last = (r_ic == ICW'(CHANNEL_NUM_IN - 1));
  assign w_x_last  = (w_x_inc >= XW'(IMAGE_WIDTH));
  assign w_y_last  = (w_y_inc >= YW'(IMAGE_HEIGHT));
  assign w_oc_last = (r_oc == OCW'(CHANNEL_NUM_OUT - 1));
  assign w_done    = (r_state == S_COMPUTE) && w_ic_last && w_x_last && w_y_last && w_oc_last;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:    if (w_start) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (w_done)  w_state_nxt = S_LOAD;
      default:   w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_w_acc) r_wmem[r_w_cnt] <= weight_in;
    if (w_p_acc) r_fmem[PFW'(r_pix_cnt)] <= pxl_in;
  end

  // Counters: oc outer, raster position, ic inner.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_w_cnt   <= '0;
      r_w_full  <= 1'b0;
      r_pix_cnt <= '0;
      r_stride  <= 1'b0;
      r_oc      <= '0;
      r_y       <= '0;
      r_x       <= '0;
      r_ic      <= '0;
    end else begin
      r_w_cnt   <= w_w_cnt_nxt;
      r_w_full  <= w_w_full_nxt;
      r_pix_cnt <= w_done ? '0 : w_pix_cnt_nxt;
      if (w_start) r_stride <= stride2;
      if (r_state == S_COMPUTE) begin
        if (!w_ic_last) begin
          r_ic <= r_ic + ICW'(1);
        end else begin
          r_ic <= '0;
          if (!w_x_last) begin
            r_x <= w_x_inc;
          end else begin
            r_x <= '0;
            if (!w_y_last) begin
              r_y <= w_y_inc;
            end else begin
              r_y  <= '0;
              r_oc <= w_oc_last ? '0 : r_oc + OCW'(1);
            end
          end
        end
      end
    end
  end

  // Nine taps in parallel; out-of-frame taps contribute zero.
  always_comb begin
    int ty, tx, pidx, widx;
    logic [DATA_WIDTH-1:0] pv;
    logic signed [63:0] prod;
    ty    = 0;
    tx    = 0;
    pidx  = 0;
    widx  = 0;
    pv    = '0;
    prod  = '0;
    w_sum = '0;
    for (int ky = 0; ky < int'(KERNEL); ky++) begin
      for (int kx = 0; kx < int'(KERNEL); kx++) begin
        ty   = int'(r_y) + (ky - int'(KERNEL) / 2) * int'(RATE);
        tx   = int'(r_x) + (kx - int'(KERNEL) / 2) * int'(RATE);
        pidx = (int'(r_ic) * int'(IMAGE_HEIGHT) + ty) * int'(IMAGE_WIDTH) + tx;
        widx = (int'(r_oc) * int'(CHANNEL_NUM_IN) + int'(r_ic)) * int'(KK) + ky * int'(KERNEL) + kx;
        pv   = '0;
        if (ty >= 0 && ty < int'(IMAGE_HEIGHT) && tx >= 0 && tx < int'(IMAGE_WIDTH))
          pv = r_fmem[PFW'(pidx)];
        prod  = 64'($signed(r_wmem[WAW'(widx)])) * 64'($signed(pv));
        w_sum = w_sum + 32'(prod >>> 16);
      end
    end
  end

  assign w_acc_nxt = (r_s1_first ? '0 : r_acc) + r_s1_sum;

`ifdef CONV_RELU_EN
  assign w_out = w_acc_nxt[DATA_WIDTH-1] ? '0 : w_acc_nxt;
`else
  assign w_out = w_acc_nxt;
`endif

  // Two-stage pipeline: tap sum register, then channel accumulation and output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sum   <= '0;
      r_acc      <= '0;
      pxl_out    <= '0;
      valid_out  <= 1'b0;
    end else begin
      r_s1_vld   <= (r_state == S_COMPUTE);
      r_s1_first <= (r_ic == '0);
      r_s1_last  <= w_ic_last;
      r_s1_sum   <= w_sum;
      valid_out  <= r_s1_vld && r_s1_last;
      if (r_s1_vld) r_acc <= w_acc_nxt;
      if (r_s1_vld && r_s1_last) pxl_out <= w_out;
    end
  end

endmodule

// File: tb/tb_cnn_conv_3x3_dilation_multi_channel.sv
// Bench for cnn_conv_3x3_dilation_multi_channel: two instances (RATE 1 multi-channel, RATE 2 single-channel)
// checked against a plain-arithmetic convolution model; honours CONV_RELU_EN.
module tb_cnn_conv_3x3_dilation_multi_channel;
  localparam int AW = 4, AH = 4, ACI = 4, ACO = 2, AR = 1;
  localparam int BW = 8, BH = 8, BCI = 1, BCO = 1, BR = 2;

  logic clk = 1'b0;
  logic reset, stride2;
  logic [31:0] pxl_in, weight_in;
  logic va, vwa, vb, vwb;
  logic [31:0] a_pxl, b_pxl;
  logic a_vld, b_vld;

  int tests = 0, fails = 0, cyc = 0, t_last = 0;
  logic [31:0] qa[$], qb[$], wa_cur[$], wb_cur[$], nullq[$];
  int ta[$], tb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_conv_3x3_dilation_multi_channel #(
    .IMAGE_WIDTH(AW), .IMAGE_HEIGHT(AH), .CHANNEL_NUM_IN(ACI), .CHANNEL_NUM_OUT(ACO),
    .KERNEL(3), .RATE(AR), .DATA_WIDTH(32)
  ) u_a (
    .clk(clk), .reset(reset), .stride2(stride2), .valid_in(va), .pxl_in(pxl_in),
    .valid_weight_in(vwa), .weight_in(weight_in), .pxl_out(a_pxl), .valid_out(a_vld)
  );

  cnn_conv_3x3_dilation_multi_channel #(
    .IMAGE_WIDTH(BW), .IMAGE_HEIGHT(BH), .CHANNEL_NUM_IN(BCI), .CHANNEL_NUM_OUT(BCO),
    .KERNEL(3), .RATE(BR), .DATA_WIDTH(32)
  ) u_b (
    .clk(clk), .reset(reset), .stride2(stride2), .valid_in(vb), .pxl_in(pxl_in),
    .valid_weight_in(vwb), .weight_in(weight_in), .pxl_out(b_pxl), .valid_out(b_vld)
  );

  always @(negedge clk) begin
    if (a_vld) begin qa.push_back(a_pxl); ta.push_back(cyc); end
    if (b_vld) begin qb.push_back(b_pxl); tb.push_back(cyc); end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: direct evaluation of the dilated convolution sum with zero padding.
  function automatic void ref_conv(input int w, input int h, input int cin, input int cout,
                                   input int rate, input bit s2, input logic [31:0] wt[$],
                                   input logic [31:0] px[$], output logic [31:0] res[$]);
    int st, acc, yy, xx;
    longint prod;
    st = s2 ? 2 : 1;
    res = {};
    for (int oc = 0; oc < cout; oc++)
      for (int y = 0; y < h; y += st)
        for (int x = 0; x < w; x += st) begin
          acc = 0;
          for (int ic = 0; ic < cin; ic++)
            for (int ky = 0; ky < 3; ky++)
              for (int kx = 0; kx < 3; kx++) begin
                yy = y + (ky - 1) * rate;
                xx = x + (kx - 1) * rate;
                if (yy >= 0 && yy < h && xx >= 0 && xx < w) begin
                  prod = longint'($signed(wt[((oc * cin + ic) * 9) + ky * 3 + kx])) *
                         longint'($signed(px[(ic * h + yy) * w + xx]));
                  acc += int'(prod >>> 16);
                end
              end
`ifdef CONV_RELU_EN
          if (acc < 0) acc = 0;
`endif
          res.push_back(32'(acc));
        end
  endfunction

  // Streams weights and pixels concurrently with random idle cycles; starts and ends on a negedge.
  task automatic load(input int sel, input bit s2, input logic [31:0] wt[$], input logic [31:0] px[$]);
    int wi, pi;
    logic vw, vp;
    wi = 0;
    pi = 0;
    qa = {}; ta = {}; qb = {}; tb = {};
    stride2 = s2;
    while (wi < wt.size() || pi < px.size()) begin
      vw = (wi < wt.size()) && ($urandom_range(0, 3) != 0);
      vp = (pi < px.size()) && ($urandom_range(0, 3) != 0);
      weight_in = vw ? wt[wi] : $urandom;
      pxl_in    = vp ? px[pi] : $urandom;
      if (sel == 0) begin vwa = vw; va = vp; end
      else          begin vwb = vw; vb = vp; end
      if (vw) wi++;
      if (vp) pi++;
      if (vw || vp) t_last = cyc;
      @(negedge clk);
    end
    va = 1'b0; vwa = 1'b0; vb = 1'b0; vwb = 1'b0;
  endtask

  task automatic check_run(input int sel, input string tag, input logic [31:0] ex[$], input int cin);
    logic [31:0] got[$];
    int tt[$], n, bad;
    for (int k = 0; k < 5000; k++) begin
      if (((sel == 0) ? qa.size() : qb.size()) >= ex.size()) break;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    if (sel == 0) begin got = qa; tt = ta; end
    else          begin got = qb; tt = tb; end
    chk({tag, " count"}, 64'(got.size()), 64'(ex.size()));
    n = (got.size() < ex.size()) ? got.size() : ex.size();
    bad = 0;
    for (int i = 0; i < n; i++)
      if (got[i] !== ex[i]) begin
        bad++;
        if (bad <= 4) $display("  %s pixel %0d: observed %h expected %h", tag, i, got[i], ex[i]);
      end
    chk({tag, " pixels wrong"}, 64'(bad), 64'(0));
    if (tt.size() > 0) chk({tag, " latency"}, 64'(tt[0] - t_last), 64'(cin + 2));
    bad = 0;
    for (int i = 1; i < tt.size(); i++) if (tt[i] - tt[i-1] != cin) bad++;
    chk({tag, " spacing"}, 64'(bad), 64'(0));
  endtask

  task automatic do_run(input int sel, input bit s2, input bit send_w, input logic [31:0] wt[$],
                        input logic [31:0] px[$], input string tag);
    logic [31:0] ex[$];
    if (send_w) begin
      if (sel == 0) wa_cur = wt; else wb_cur = wt;
    end
    if (sel == 0) ref_conv(AW, AH, ACI, ACO, AR, s2, wa_cur, px, ex);
    else          ref_conv(BW, BH, BCI, BCO, BR, s2, wb_cur, px, ex);
    if (send_w) load(sel, s2, wt, px);
    else        load(sel, s2, nullq, px);
    check_run(sel, tag, ex, (sel == 0) ? ACI : BCI);
  endtask

  initial begin
    logic [31:0] wt[$], px[$];
    reset = 1'b0; stride2 = 1'b0; pxl_in = '0; weight_in = '0;
    va = 1'b0; vwa = 1'b0; vb = 1'b0; vwb = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset a_vld", 64'(a_vld), 64'(0));
    chk("reset a_pxl", 64'(a_pxl), 64'(0));
    chk("reset b_vld", 64'(b_vld), 64'(0));
    chk("reset b_pxl", 64'(b_pxl), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Identity on B: center weight 1.0, output equals input.
    wt = {}; px = {};
    for (int i = 0; i < 9; i++) wt.push_back((i == 4) ? 32'h0001_0000 : 32'h0);
    for (int i = 0; i < BW * BH; i++) px.push_back(32'(i) << 16);
    do_run(1, 1'b0, 1'b1, wt, px, "b_identity");
    chk("b_identity px9", 64'(qb[9]), 64'(32'h0009_0000));

    // All ones on A: corner / edge / interior sums.
    wt = {}; px = {};
    for (int i = 0; i < 9 * ACI * ACO; i++) wt.push_back(32'h0001_0000);
    for (int i = 0; i < ACI * AH * AW; i++) px.push_back(32'h0001_0000);
    do_run(0, 1'b0, 1'b1, wt, px, "a_ones");
    chk("a_ones corner", 64'(qa[0]), 64'(32'h0010_0000));
    chk("a_ones edge", 64'(qa[1]), 64'(32'h0018_0000));
    chk("a_ones interior", 64'(qa[5]), 64'(32'h0024_0000));
    chk("a_ones last corner", 64'(qa[15]), 64'(32'h0010_0000));

    // Stride 2 with retained weights.
    do_run(0, 1'b1, 1'b0, wt, px, "a_stride");
    chk("a_stride p0", 64'(qa[0]), 64'(32'h0010_0000));
    chk("a_stride p1", 64'(qa[1]), 64'(32'h0018_0000));
    chk("a_stride p2", 64'(qa[2]), 64'(32'h0018_0000));
    chk("a_stride p3", 64'(qa[3]), 64'(32'h0024_0000));

    // Dilation on B: top-left tap only, out(y,x) = in(y-2,x-2).
    wt = {}; px = {};
    for (int i = 0; i < 9; i++) wt.push_back((i == 0) ? 32'h0001_0000 : 32'h0);
    for (int i = 0; i < BW * BH; i++) px.push_back($urandom);
    do_run(1, 1'b0, 1'b1, wt, px, "b_dilation");
    chk("b_dilation (0,5)", 64'(qb[5]), 64'(0));
    chk("b_dilation (3,4)", 64'(qb[3 * BW + 4]), 64'(px[1 * BW + 2]));

    // Random full-range weights and pixels (exercises wraparound).
    for (int r = 0; r < 2; r++) begin
      wt = {}; px = {};
      for (int i = 0; i < 9 * ACI * ACO; i++) wt.push_back($urandom);
      for (int i = 0; i < ACI * AH * AW; i++) px.push_back($urandom);
      do_run(0, 1'($urandom_range(0, 1)), 1'b1, wt, px, "a_random");
    end
    wt = {}; px = {};
    for (int i = 0; i < 9; i++) wt.push_back($urandom_range(0, 32'h0003_ffff) - 32'h0002_0000);
    for (int i = 0; i < BW * BH; i++) px.push_back($urandom);
    do_run(1, 1'b1, 1'b1, wt, px, "b_random_s2");
    px = {};
    for (int i = 0; i < BW * BH; i++) px.push_back($urandom);
    do_run(1, 1'b0, 1'b0, wt, px, "b_retained");

    // Negative result: -1.0 * 2.0.
    wt = {}; px = {};
    for (int i = 0; i < 9; i++) wt.push_back((i == 4) ? 32'hFFFF_0000 : 32'h0);
    for (int i = 0; i < BW * BH; i++) px.push_back(32'h0002_0000);
    do_run(1, 1'b0, 1'b1, wt, px, "b_negative");
`ifdef CONV_RELU_EN
    chk("b_negative relu", 64'(qb[27]), 64'(32'h0000_0000));
`else
    chk("b_negative raw", 64'(qb[27]), 64'(32'hFFFE_0000));
`endif

    // Reset during the third output of A, then a fresh complete frame.
    wt = {}; px = {};
    for (int i = 0; i < 9 * ACI * ACO; i++) wt.push_back($urandom);
    for (int i = 0; i < ACI * AH * AW; i++) px.push_back($urandom);
    load(0, 1'b0, wt, px);
    for (int k = 0; k < 2000 && qa.size() < 2; k++) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset a_vld", 64'(a_vld), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("midreset no more outputs", 64'(qa.size()), 64'(2));
    wt = {}; px = {};
    for (int i = 0; i < 9 * ACI * ACO; i++) wt.push_back($urandom);
    for (int i = 0; i < ACI * AH * AW; i++) px.push_back($urandom);
    do_run(0, 1'b0, 1'b1, wt, px, "a_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
